// File: rtl/receiver_pkg.sv
// Shared definitions for the receiver group arbiter: FSM state
// encoding, default parameter values and the group index width helper.
package receiver_pkg;

    localparam int N_GROUPS_DEF = 2;
    localparam int FRAME_W_DEF  = 272;
    localparam int TS_W_DEF     = 24;
    localparam int SEQ_W        = 16;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_PRESENT  = 2'd1;
    localparam logic [1:0] ST_RELEASE  = 2'd2;
    localparam logic [1:0] ST_WAIT_CLR = 2'd3;

    // Group index width; a single group still needs one bit.
    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector over the per-group request vector.
// Ports: req (requests), last_grant (previous winner), grant (winner
// index), any_grant (at least one request present).
module rr_arbiter #(
    parameter int N    = 2,
    parameter int ID_W = 1
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] last_grant,
    output logic [ID_W-1:0] grant,
    output logic            any_grant
);

    int idx;

    // Search starts one past the previous winner and wraps once around.
    always_comb begin
        grant     = '0;
        any_grant = 1'b0;
        idx       = 0;
        for (int i = 1; i <= N; i++) begin
            idx = int'(last_grant) + i;
            if (idx >= N) begin
                idx = idx - N;
            end
            for (int g = 0; g < N; g++) begin
                if (!any_grant && (g == idx) && req[g]) begin
                    any_grant = 1'b1;
                    grant     = ID_W'(g);
                end
            end
        end
    end

endmodule

// File: rtl/receiver_group_arbiter.sv
// Arbitrates octo sensor groups onto one valid/ready frame stream, tagging
// each frame with group index, capture timestamp and sequence number.
// Ports: clk_96MHz, reset (async, active high), data_avl/sensor_iterations
// (per-group frame inputs), reset_parser (per-group consumed pulse),
// sys_ts (free-running timestamp), out_valid/out_ready handshake and
// out_group/out_ts/out_seq/out_frame payload.
module receiver_group_arbiter
    import receiver_pkg::*;
#(
    parameter int N_GROUPS = N_GROUPS_DEF,
    parameter int FRAME_W  = FRAME_W_DEF,
    parameter int TS_W     = TS_W_DEF,
    parameter int ID_W     = id_w(N_GROUPS)
) (
    input  logic                        clk_96MHz,
    input  logic                        reset,
    input  logic [N_GROUPS-1:0]         data_avl,
    input  logic [N_GROUPS*FRAME_W-1:0] sensor_iterations,
    output logic [N_GROUPS-1:0]         reset_parser,
    output logic [TS_W-1:0]             sys_ts,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [ID_W-1:0]             out_group,
    output logic [TS_W-1:0]             out_ts,
    output logic [SEQ_W-1:0]            out_seq,
    output logic [FRAME_W-1:0]          out_frame
);

    logic [1:0]         state_q;
    logic [ID_W-1:0]    last_grant_q;
    logic [ID_W-1:0]    grant;
    logic               any_grant;
    logic [FRAME_W-1:0] sel_frame;
    logic               cur_avl;

    rr_arbiter #(
        .N    (N_GROUPS),
        .ID_W (ID_W)
    ) u_rr (
        .req        (data_avl),
        .last_grant (last_grant_q),
        .grant      (grant),
        .any_grant  (any_grant)
    );

    // Mux the winning group's frame with constant slices only.
    always_comb begin
        sel_frame = '0;
        for (int g = 0; g < N_GROUPS; g++) begin
            if (grant == ID_W'(g)) begin
                sel_frame = sensor_iterations[g*FRAME_W +: FRAME_W];
            end
        end
    end

    // Frame-ready level of the group currently being served.
    always_comb begin
        cur_avl = 1'b0;
        for (int g = 0; g < N_GROUPS; g++) begin
            if (out_group == ID_W'(g)) begin
                cur_avl = data_avl[g];
            end
        end
    end

    always_ff @(posedge clk_96MHz or posedge reset) begin
        if (reset) begin
            sys_ts <= '0;
        end else begin
            sys_ts <= sys_ts + 1'b1;
        end
    end

    always_ff @(posedge clk_96MHz or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= ID_W'(N_GROUPS - 1);
            out_valid    <= 1'b0;
            out_group    <= '0;
            out_ts       <= '0;
            out_seq      <= '0;
            out_frame    <= '0;
            reset_parser <= '0;
        end else begin
            reset_parser <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (any_grant) begin
                        out_frame    <= sel_frame;
                        out_group    <= grant;
                        out_ts       <= sys_ts;
                        last_grant_q <= grant;
                        out_valid    <= 1'b1;
                        state_q      <= ST_PRESENT;
                    end
                end
                ST_PRESENT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_seq   <= out_seq + 16'd1;
                        for (int g = 0; g < N_GROUPS; g++) begin
                            if (out_group == ID_W'(g)) begin
                                reset_parser[g] <= 1'b1;
                            end
                        end
                        state_q <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    state_q <= ST_WAIT_CLR;
                end
                ST_WAIT_CLR: begin
                    // The parser drops data_avl a little after the pulse;
                    // never recapture the same frame while it is still up.
                    if (!cur_avl) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/receiver_group_arbiter.md
RECEIVER_GROUP_ARBITER -- requirements
Module: receiver_group_arbiter

Interface
REQ-001 The block SHALL have parameter N_GROUPS, default 2, giving the number of octo sensor groups arbitrated (range 1..8).
REQ-002 The block SHALL have parameter FRAME_W, default 272, giving the width of one group's sensor_iterations frame.
REQ-003 The block SHALL have parameter TS_W, default 24, giving the width of the system timestamp.
REQ-004 The block SHALL have derived constant ID_W = max(1, clog2(N_GROUPS)), giving the group index width.
REQ-005 The block SHALL have port clk_96MHz  in  1  sole clock; all logic is on its rising edge.
REQ-006 The block SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-007 The block SHALL have port data_avl  in  N_GROUPS  per-group frame-ready level.
REQ-008 The block SHALL have port sensor_iterations  in  N_GROUPS*FRAME_W  group g occupies bits [g*FRAME_W +: FRAME_W].
REQ-009 The block SHALL have port reset_parser  out  N_GROUPS  per-group one-cycle frame-consumed pulse.
REQ-010 The block SHALL have port sys_ts  out  TS_W  free-running timestamp shared with the groups.
REQ-011 The block SHALL have port out_valid  in/out as out  1  frame offered to the serial transmitter.
REQ-012 The block SHALL have port out_ready  in  1  transmitter accepts the frame.
REQ-013 The block SHALL have ports out_group (out, ID_W), out_ts (out, TS_W), out_seq (out, 16) and out_frame (out, FRAME_W), carrying the tagged frame.

Function
REQ-014 sys_ts SHALL increment by 1 every cycle and wrap from all-ones to 0.
REQ-015 The FSM SHALL have states IDLE, PRESENT, RELEASE and WAIT_CLR.
REQ-016 In IDLE, when any data_avl bit is high, the block SHALL grant one group round-robin, starting the search at last_grant+1 modulo N_GROUPS.
REQ-017 On a grant in cycle t, the block SHALL capture the group's frame, the group index and the cycle-t sys_ts, and SHALL enter PRESENT so that out_valid is high at t+1 (latency 1).
REQ-018 In PRESENT, out_valid SHALL stay high and out_group/out_ts/out_seq/out_frame SHALL stay stable until out_valid & out_ready.
REQ-019 After a handshake, the FSM SHALL go to RELEASE, and out_valid SHALL be low in the following cycle.
REQ-020 In RELEASE, reset_parser[g] SHALL be high for exactly one cycle, and the FSM SHALL then go to WAIT_CLR.
REQ-021 WAIT_CLR SHALL return to IDLE once data_avl[g] is low; a still-high data_avl[g] SHALL never be re-captured.
REQ-022 out_seq SHALL increment by 1 per accepted frame, wrapping at 16'hFFFF to 0, and SHALL tag the frame with its pre-increment value.
REQ-023 When several groups are simultaneously high, exactly one group SHALL be granted and the others SHALL remain pending; no frame SHALL be dropped.
REQ-024 A change of data_avl or sensor_iterations during PRESENT SHALL NOT alter the presented outputs.
REQ-025 With N_GROUPS=1, the block SHALL always grant group 0 and out_group SHALL be 0.

Reset
REQ-026 Asserting reset SHALL immediately clear sys_ts, out_valid, out_group, out_ts, out_seq, out_frame and reset_parser to 0, and SHALL force the FSM to IDLE.
REQ-027 Reset SHALL set last_grant to N_GROUPS-1, so group 0 wins first after reset.
REQ-028 Reset asserted mid-PRESENT SHALL abandon the frame without issuing reset_parser; after reset the frame is re-captured from a still-high data_avl.

Structure
REQ-029 The FSM state encoding, default parameter values and the ID_W derivation SHALL live in shared package receiver_pkg.
REQ-030 Round-robin selection SHALL be a separate combinational sub-module rr_arbiter (inputs: req vector, last_grant; outputs: grant index, any_grant).
REQ-031 Frame storage SHALL be a single FRAME_W register; no per-group buffers SHALL be used.

Verification
REQ-032 After reset, hold out_ready=1 and raise data_avl=2'b01 at cycle 10 -> out_valid at cycle 11, out_group=0, out_ts=10, out_seq=0, reset_parser[0] pulses at cycle 12.
REQ-033 Raise data_avl=2'b11 together, with out_ready=1 -> group 0 is served, then group 1; out_seq=0,1; each reset_parser bit pulses once.
REQ-034 Hold out_ready=0 for 50 cycles while changing sensor_iterations -> out_valid stays 1 and out_frame stays unchanged; out_ready=1 -> one handshake only.
REQ-035 Keep data_avl[0] high for 20 cycles after its reset_parser pulse -> no second capture until it falls and rises again.
REQ-036 Assert reset during PRESENT -> all outputs are 0 that same cycle, no reset_parser pulse occurs, and the frame is re-presented with out_seq=0.
REQ-037 Force sys_ts to 24'hFFFFFF -> the next value is 0, and a frame captured on that cycle carries out_ts=24'hFFFFFF.
